shake_absorb_buffer_ctrl: RTL and testbench
===========================================

Name: shake_absorb_buffer_ctrl

Overview:
- Input-side controller for the SHAKE permute FSM.
- Accepts a 64-bit little-endian message word stream and packs it into a rate-sized block register.
- Applies SHAKE padding: domain byte 0x1F, final bit 0x80.
- Presents each block to the permute FSM using the input_buffer_ready / last_block_in_input_buffer flag handshake, with clears issued by the consumer.

Parameters:
- W, 64: word/lane width in bits; fixed at 64 (Keccak lane).
- MAX_LANES, 21: block register depth in lanes (SHAKE128 rate = 168 B).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  pulse in IDLE: latch mode, clear block register, begin a message
- mode  in  1  0 = SHAKE128 (rate 21 lanes), 1 = SHAKE256 (rate 17 lanes)
- in_valid  in  1  message word valid
- in_ready  out  1  word accepted when in_valid && in_ready
- in_data  in  W  message word; byte 0 = bits [7:0]
- in_last  in  1  final word of the message
- in_bytes  in  4  valid bytes in the final word, 0..8; sampled only with in_last
- block_data  out  W*MAX_LANES  block register; lane i = bits [64i+63:64i]
- input_buffer_ready  out  1  block complete and valid
- last_block_in_input_buffer  out  1  held block is the padded final block
- input_buffer_ready_clr  in  1  consumer has absorbed the block
- last_block_in_buffer_clr  in  1  consumer has acknowledged the last flag
- busy  out  1  not in IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - State goes to IDLE. block_data = 0, lane_cnt = 0, pad_pending = 0.
  - All outputs are 0: in_ready = 0, input_buffer_ready = 0, last_block_in_input_buffer = 0, busy = 0.
  - rst mid-message discards all partial data.
- Latched values: rate R = 21 or 17 lanes, from mode latched at start. Lanes >= R are held at 0.
- States: IDLE, FILL, FULL, PAD.
- IDLE:
  - in_ready = 0.
  - On start: latch mode, zero block_data, lane_cnt = 0, go to FILL. Next cycle busy = 1.
- FILL: in_ready = 1. On each accepted word, write it to lane lane_cnt.
  - Not in_last:
    - lane_cnt == R-1: go to FULL, set input_buffer_ready, lane_cnt = 0.
    - Otherwise: lane_cnt++.
  - in_last, padding position p = 8*lane_cnt + in_bytes:
    - p < 8R: bytes at p and above in the block are zeroed. Byte p ^= 0x1F, byte 8R-1 ^= 0x80; if p = 8R-1 this byte becomes 0x9F. Set input_buffer_ready and last_block_in_input_buffer, go to FULL.
    - p == 8R (lane R-1 with 8 bytes): block is full with no room for padding. Set input_buffer_ready only, set pad_pending = 1, go to FULL.
  - Masking: bytes >= in_bytes of the last word are forced to 0 before padding.
  - in_bytes = 0 with in_last is legal; the empty message gives byte 0 = 0x1F, byte 8R-1 = 0x80.
  - in_bytes > 8 is illegal; the bench asserts on it.
- FULL:
  - in_ready = 0; block_data is held stable.
  - On input_buffer_ready_clr: clear input_buffer_ready and zero block_data, with destination by priority:
    - pad_pending: go to PAD.
    - Block was last: go to IDLE.
    - Otherwise: go to FILL.
  - Flags are owned independently:
    - last_block_in_input_buffer clears only on last_block_in_buffer_clr, which may arrive in the same cycle as input_buffer_ready_clr, or earlier.
    - A clr input while its flag is already 0 has no effect.
- PAD: one cycle. block_data = pad-only block (byte 0 = 0x1F, byte 8R-1 = 0x80). Set input_buffer_ready and last_block_in_input_buffer, clear pad_pending, go to FULL.
- Latency: the accepted word that completes a block causes input_buffer_ready = 1 on the next cycle. A word is never accepted in the cycle a clr is seen.
- start outside IDLE is ignored. mode changes after start are ignored until the next start.
- A new start while last_block_in_input_buffer is still 1 is allowed; the flag clears only via its clr.

Decomposition:
- Shared package shake_pkg:
  - Constants: RATE_LANES_128 = 21, RATE_LANES_256 = 17, DOMAIN_SHAKE = 8'h1F, PAD_FINAL = 8'h80.
  - State enum absorb_state_t.
- Sub-module shake_pad_gen: combinational block-level padder.
  - Inputs: current block, lane index, in_bytes, R.
  - Output: padded block.
  - Used by FILL-last and PAD; keeps the FSM small.

Test Plan:
- SHAKE128, empty message (start, single word in_last = 1, in_bytes = 0) -> one block; lane 0 = 0x1F, lane 20 = 0x8000000000000000, both flags = 1.
- SHAKE256, 3 words + final in_bytes = 3 (data 0xAABBCC) -> lane 3 = 0x0000_0000_1FAA_BBCC, lane 16 bit 63 set, lanes 17-20 = 0, last = 1.
- SHAKE256, exactly 17 full words, last in_bytes = 8:
  - First block: ready = 1, last = 0, pad_pending = 1.
  - After clr: PAD block with lane 0 = 0x1F, lane 16 = 0x80<<56, last = 1.
- SHAKE128, 20 words + final in_bytes = 7 -> byte 167 = 0x9F; single last block.
- Hold input_buffer_ready_clr low for 10 cycles during multi-block message -> in_ready = 0 and block_data stable throughout; resumes FILL on the cycle after clr.
- Assert rst mid-FILL (lane_cnt = 5) -> outputs 0, state IDLE; the next message produces correct blocks with no stale lanes.

Source files
------------

// File: rtl/shake_pkg.sv
// Shared constants and state encoding for the SHAKE absorb-side buffer logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shake_pkg;

  // Rate in 64-bit lanes for each SHAKE variant.
  localparam int RATE_LANES_128 = 21;
  localparam int RATE_LANES_256 = 17;

  // SHAKE domain-separation byte and the final pad bit of a block.
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_FINAL    = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL,
    ST_PAD
  } absorb_state_t;

endpackage

// File: rtl/shake_pad_gen.sv
// Combinational SHAKE block padder: keeps bytes below the pad position, then applies 0x1F / 0x80.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: blk_in (block with the final word already written), lane_idx (lane of the final word),
//        in_bytes (valid bytes in that word, 0..8), rate (rate in lanes), blk_out (padded block).
module shake_pad_gen
  import shake_pkg::*;
#(
  parameter int W         = 64,
  parameter int MAX_LANES = 21
) (
  input  logic [W*MAX_LANES-1:0]         blk_in,
  input  logic [$clog2(MAX_LANES)-1:0]   lane_idx,
  input  logic [3:0]                     in_bytes,
  input  logic [$clog2(MAX_LANES)-1:0]   rate,
  output logic [W*MAX_LANES-1:0]         blk_out
);
  localparam int LCW = $clog2(MAX_LANES);
  localparam int PW  = LCW + 3;
  localparam int NB  = W * MAX_LANES / 8;

  logic [PW-1:0] pad_pos;
  logic [PW-1:0] end_pos;
  logic [7:0]    byte_v;

  always_comb begin
    pad_pos = {lane_idx, 3'b000} + PW'(in_bytes);
    end_pos = {rate, 3'b000} - PW'(1);
    blk_out = '0;
    byte_v  = 8'h00;
    for (int b = 0; b < NB; b++) begin
      // Bytes at or past the pad position are message garbage or stale; drop them.
      byte_v = (PW'(b) < pad_pos) ? blk_in[8*b +: 8] : 8'h00;
      // XOR (not assign) so that pad_pos == end_pos naturally yields 0x9F.
      if (PW'(b) == pad_pos) byte_v = byte_v ^ DOMAIN_SHAKE;
      if (PW'(b) == end_pos) byte_v = byte_v ^ PAD_FINAL;
      // Lanes beyond the rate never carry data.
      if (PW'(b) > end_pos)  byte_v = 8'h00;
      blk_out[8*b +: 8] = byte_v;
    end
  end

endmodule

// File: rtl/shake_absorb_buffer_ctrl.sv
// Packs a 64-bit LE word stream into a SHAKE rate block, pads the tail, hands blocks to the permute FSM.
// Latency: the word completing a block raises input_buffer_ready on the next cycle; pad-only block 2 cycles after clr.
// Backpressure: in_ready drops while a block is held; resumes the cycle after input_buffer_ready_clr.
// Ports: start/mode begin a message; in_valid/in_ready/in_data/in_last/in_bytes word stream;
//        block_data + input_buffer_ready/last_block_in_input_buffer to consumer, cleared by the two *_clr inputs;
//        busy is high whenever the controller is not idle.
module shake_absorb_buffer_ctrl
  import shake_pkg::*;
#(
  parameter int W         = 64,
  parameter int MAX_LANES = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic                   in_last,
  input  logic [3:0]             in_bytes,
  output logic [W*MAX_LANES-1:0] block_data,
  output logic                   input_buffer_ready,
  output logic                   last_block_in_input_buffer,
  input  logic                   input_buffer_ready_clr,
  input  logic                   last_block_in_buffer_clr,
  output logic                   busy
);
  localparam int LCW = $clog2(MAX_LANES);
  localparam int PW  = LCW + 3;

  absorb_state_t          state;
  logic [LCW-1:0]         lane_cnt;
  logic [LCW-1:0]         rate;
  logic                   pad_pending;
  // Remembers that the held block is final even if the consumer already cleared the visible flag.
  logic                   blk_last;

  logic                   word_acc;
  logic [PW-1:0]          pad_pos;
  logic                   last_fits;
  logic [W*MAX_LANES-1:0] blk_with_word;
  logic [W*MAX_LANES-1:0] pad_src;
  logic [W*MAX_LANES-1:0] pad_out;
  logic [LCW-1:0]         pad_lane;
  logic [3:0]             pad_bytes;

  always_comb begin
    word_acc  = (state == ST_FILL) && in_valid && in_ready;
    pad_pos   = {lane_cnt, 3'b000} + PW'(in_bytes);
    last_fits = pad_pos < {rate, 3'b000};

    blk_with_word = block_data;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (lane_cnt == LCW'(i)) blk_with_word[i*W +: W] = in_data;
    end

    // PAD state reuses the padder on an empty block at position 0.
    if (state == ST_PAD) begin
      pad_src   = '0;
      pad_lane  = '0;
      pad_bytes = 4'd0;
    end else begin
      pad_src   = blk_with_word;
      pad_lane  = lane_cnt;
      pad_bytes = in_bytes;
    end
  end

  shake_pad_gen #(
    .W         (W),
    .MAX_LANES (MAX_LANES)
  ) u_pad_gen (
    .blk_in   (pad_src),
    .lane_idx (pad_lane),
    .in_bytes (pad_bytes),
    .rate     (rate),
    .blk_out  (pad_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                      <= ST_IDLE;
      lane_cnt                   <= '0;
      rate                       <= LCW'(RATE_LANES_128);
      pad_pending                <= 1'b0;
      blk_last                   <= 1'b0;
      block_data                 <= '0;
      in_ready                   <= 1'b0;
      input_buffer_ready         <= 1'b0;
      last_block_in_input_buffer <= 1'b0;
      busy                       <= 1'b0;
    end else begin
      // A set below (new final block) overrides a coincident clear aimed at an older flag.
      if (last_block_in_buffer_clr) last_block_in_input_buffer <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            rate        <= mode ? LCW'(RATE_LANES_256) : LCW'(RATE_LANES_128);
            block_data  <= '0;
            lane_cnt    <= '0;
            pad_pending <= 1'b0;
            blk_last    <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (word_acc) begin
            if (in_last) begin
              in_ready           <= 1'b0;
              input_buffer_ready <= 1'b1;
              lane_cnt           <= '0;
              state              <= ST_FULL;
              if (last_fits) begin
                block_data                 <= pad_out;
                last_block_in_input_buffer <= 1'b1;
                blk_last                   <= 1'b1;
              end else begin
                // Message ends exactly on the block boundary: padding goes in a block of its own.
                block_data  <= blk_with_word;
                pad_pending <= 1'b1;
              end
            end else if (lane_cnt == rate - 1'b1) begin
              block_data         <= blk_with_word;
              in_ready           <= 1'b0;
              input_buffer_ready <= 1'b1;
              lane_cnt           <= '0;
              state              <= ST_FULL;
            end else begin
              block_data <= blk_with_word;
              lane_cnt   <= lane_cnt + 1'b1;
            end
          end
        end

        ST_FULL: begin
          if (input_buffer_ready_clr) begin
            input_buffer_ready <= 1'b0;
            block_data         <= '0;
            if (pad_pending) begin
              state <= ST_PAD;
            end else if (blk_last) begin
              blk_last <= 1'b0;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_FILL;
            end
          end
        end

        ST_PAD: begin
          block_data                 <= pad_out;
          input_buffer_ready         <= 1'b1;
          last_block_in_input_buffer <= 1'b1;
          blk_last                   <= 1'b1;
          pad_pending                <= 1'b0;
          state                      <= ST_FULL;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_absorb_buffer_ctrl.sv
// Self-checking bench for shake_absorb_buffer_ctrl: random messages vs a byte-level SHAKE padding model.
// Latency: n/a (testbench).
// Backpressure: producer honours in_ready; consumer stalls clears for random/held intervals.
module tb_shake_absorb_buffer_ctrl;
  localparam int W  = 64;
  localparam int ML = 21;
  localparam int BW = W * ML;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic [BW-1:0] block_data;
  logic          input_buffer_ready;
  logic          last_block_in_input_buffer;
  logic          input_buffer_ready_clr;
  logic          last_block_in_buffer_clr;
  logic          busy;

  int tests = 0;
  int fails = 0;
  bit chk_resume = 1'b0;

  logic [7:0]    msg[$];
  logic [BW-1:0] exp_blk[$];
  bit            exp_last[$];
  logic [BW-1:0] got_blk[$];

  shake_absorb_buffer_ctrl #(.W(W), .MAX_LANES(ML)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .mode                       (mode),
    .in_valid                   (in_valid),
    .in_ready                   (in_ready),
    .in_data                    (in_data),
    .in_last                    (in_last),
    .in_bytes                   (in_bytes),
    .block_data                 (block_data),
    .input_buffer_ready         (input_buffer_ready),
    .last_block_in_input_buffer (last_block_in_input_buffer),
    .input_buffer_ready_clr     (input_buffer_ready_clr),
    .last_block_in_buffer_clr   (last_block_in_buffer_clr),
    .busy                       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_last) assert (in_bytes <= 4'd8) else $error("in_bytes above 8 on final word");
  end

  // Reference: append 0x1F after the message, zero-fill to a whole number of rate blocks, XOR 0x80 into the last byte.
  task automatic build_expected(input bit md);
    int len;
    int rb;
    int total;
    logic [7:0] pb[];
    logic [BW-1:0] blk;
    len   = msg.size();
    rb    = md ? 136 : 168;
    total = ((len + rb) / rb) * rb;
    pb    = new[total];
    for (int i = 0; i < total; i++) pb[i] = (i < len) ? msg[i] : 8'h00;
    pb[len]     = pb[len] ^ 8'h1F;
    pb[total-1] = pb[total-1] ^ 8'h80;
    exp_blk.delete();
    exp_last.delete();
    for (int b = 0; b < total / rb; b++) begin
      blk = '0;
      for (int j = 0; j < rb; j++) blk[8*j +: 8] = pb[b*rb + j];
      exp_blk.push_back(blk);
      exp_last.push_back(b == total / rb - 1);
    end
  endtask

  task automatic rand_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  // Called at a negedge; returns at the negedge after the word was taken.
  task automatic send_word(input logic [W-1:0] d, input logic l, input logic [3:0] b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_bytes = b;
    while (in_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic produce();
    int len;
    int n;
    logic [W-1:0] d;
    len = msg.size();
    n   = (len == 0) ? 1 : (len + 7) / 8;
    for (int w = 0; w < n; w++) begin
      for (int j = 0; j < 8; j++)
        d[8*j +: 8] = (8*w + j < len) ? msg[8*w + j] : 8'($urandom);
      send_word(d, (w == n - 1), (w == n - 1) ? 4'(len - 8*w) : 4'd8);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic consume(input int hold, input bit keep_last);
    int nb;
    int guard;
    int lane;
    bit stall_bad;
    bit early;
    bit exp_l;
    nb = exp_blk.size();
    for (int k = 0; k < nb; k++) begin
      guard = 0;
      while (input_buffer_ready !== 1'b1 && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      tests++;
      if (guard >= 3000) begin
        fails++;
        $display("FAIL block_timeout: blk %0d input_buffer_ready=%b, required 1", k, input_buffer_ready);
        return;
      end
      if (block_data !== exp_blk[k]) begin
        lane = 0;
        for (int i = ML - 1; i >= 0; i--) if (block_data[64*i +: 64] !== exp_blk[k][64*i +: 64]) lane = i;
        fails++;
        $display("FAIL block_data: blk %0d lane %0d got %h required %h", k, lane,
                 block_data[64*lane +: 64], exp_blk[k][64*lane +: 64]);
      end
      tests++;
      if (last_block_in_input_buffer !== exp_last[k]) begin
        fails++;
        $display("FAIL last_flag: blk %0d got %b required %b", k, last_block_in_input_buffer, exp_last[k]);
      end
      got_blk.push_back(block_data);

      stall_bad = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (in_ready !== 1'b0 || input_buffer_ready !== 1'b1 || block_data !== exp_blk[k]) stall_bad = 1'b1;
      end
      if (hold > 0) begin
        tests++;
        if (stall_bad) begin
          fails++;
          $display("FAIL stall_hold: blk %0d held state changed (in_ready=%b ready=%b), required stable",
                   k, in_ready, input_buffer_ready);
        end
      end

      early = 1'($urandom_range(0, 1));
      if (exp_last[k] && !keep_last && early) begin
        last_block_in_buffer_clr = 1'b1;
        @(negedge clk);
        last_block_in_buffer_clr = 1'b0;
        tests++;
        if (last_block_in_input_buffer !== 1'b0 || input_buffer_ready !== 1'b1) begin
          fails++;
          $display("FAIL early_last_clr: last=%b ready=%b, required last=0 ready=1",
                   last_block_in_input_buffer, input_buffer_ready);
        end
      end
      input_buffer_ready_clr = 1'b1;
      if (exp_last[k] && !keep_last && !early) last_block_in_buffer_clr = 1'b1;
      @(negedge clk);
      input_buffer_ready_clr   = 1'b0;
      last_block_in_buffer_clr = 1'b0;
      exp_l = keep_last && exp_last[k];
      tests++;
      if (input_buffer_ready !== 1'b0 || last_block_in_input_buffer !== exp_l) begin
        fails++;
        $display("FAIL clr_ack: blk %0d ready=%b last=%b, required ready=0 last=%b",
                 k, input_buffer_ready, last_block_in_input_buffer, exp_l);
      end
      if (chk_resume && !exp_last[k]) begin
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL resume_fill: in_ready=%b one cycle after clr, required 1", in_ready);
        end
      end
      if (k == nb - 1) begin
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL busy_end: busy=%b after final block, required 0", busy);
        end
      end
    end
  endtask

  task automatic run_message(input bit md, input int hold, input bit keep_last, input bit do_start);
    got_blk.delete();
    build_expected(md);
    if (do_start) begin
      mode  = md;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode  = 1'($urandom);  // must be ignored until the next start
    end
    fork
      produce();
      consume(hold, keep_last);
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
    tests++;
    if (input_buffer_ready !== 1'b0 || last_block_in_input_buffer !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: ready=%b last=%b, required 0 0", input_buffer_ready, last_block_in_input_buffer);
    end
    tests++;
    if (block_data !== '0) begin
      fails++;
      $display("FAIL reset_block: lane0=%h, required all zero", block_data[63:0]);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_empty_128();
    logic [BW-1:0] lb;
    rand_msg(0);
    run_message(1'b0, 0, 1'b0, 1'b1);
    lb = got_blk[0];
    tests++;
    if (lb[63:0] !== 64'h1F || lb[20*64 +: 64] !== 64'h8000_0000_0000_0000) begin
      fails++;
      $display("FAIL empty128: lane0=%h lane20=%h, required 1f 8000000000000000", lb[63:0], lb[20*64 +: 64]);
    end
  endtask

  task automatic test_partial_256();
    logic [BW-1:0] lb;
    rand_msg(24);
    msg.push_back(8'hCC);
    msg.push_back(8'hBB);
    msg.push_back(8'hAA);
    run_message(1'b1, 1, 1'b0, 1'b1);
    lb = got_blk[0];
    tests++;
    if (lb[3*64 +: 64] !== 64'h0000_0000_1FAA_BBCC || lb[16*64 + 63] !== 1'b1) begin
      fails++;
      $display("FAIL partial256: lane3=%h lane16=%h, required 000000001faabbcc and bit63 set",
               lb[3*64 +: 64], lb[16*64 +: 64]);
    end
    tests++;
    if (lb[BW-1:17*64] !== '0) begin
      fails++;
      $display("FAIL partial256_upper: lanes17-20 nonzero (lane17=%h), required 0", lb[17*64 +: 64]);
    end
  endtask

  task automatic test_exact_rate_256();
    logic [BW-1:0] lb;
    rand_msg(136);
    run_message(1'b1, 0, 1'b0, 1'b1);
    tests++;
    if (got_blk.size() !== 2) begin
      fails++;
      $display("FAIL exact256_count: blocks=%0d, required 2", got_blk.size());
    end else begin
      lb = got_blk[1];
      tests++;
      if (lb[63:0] !== 64'h1F || lb[16*64 +: 64] !== 64'h8000_0000_0000_0000) begin
        fails++;
        $display("FAIL exact256_pad: lane0=%h lane16=%h, required 1f 8000000000000000", lb[63:0], lb[16*64 +: 64]);
      end
    end
  endtask

  task automatic test_9f_128();
    logic [BW-1:0] lb;
    rand_msg(167);
    run_message(1'b0, 0, 1'b0, 1'b1);
    lb = got_blk[0];
    tests++;
    if (got_blk.size() !== 1 || lb[167*8 +: 8] !== 8'h9F) begin
      fails++;
      $display("FAIL byte9f: blocks=%0d byte167=%h, required 1 9f", got_blk.size(), lb[167*8 +: 8]);
    end
  endtask

  task automatic test_stall();
    rand_msg(300);
    chk_resume = 1'b1;
    run_message(1'b0, 10, 1'b0, 1'b1);
    chk_resume = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 5; w++) send_word({$urandom, $urandom}, 1'b0, 4'd8);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || input_buffer_ready !== 1'b0 || last_block_in_input_buffer !== 1'b0) begin
      fails++;
      $display("FAIL midfill_rst: in_ready=%b busy=%b ready=%b last=%b, required all 0",
               in_ready, busy, input_buffer_ready, last_block_in_input_buffer);
    end
    tests++;
    if (block_data !== '0) begin
      fails++;
      $display("FAIL midfill_rst_block: lane0=%h, required all zero", block_data[63:0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rand_msg(20);
    run_message(1'b1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_start_with_last();
    rand_msg(0);
    run_message(1'b0, 0, 1'b1, 1'b1);
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || last_block_in_input_buffer !== 1'b1) begin
      fails++;
      $display("FAIL start_keeps_last: busy=%b last=%b, required 1 1", busy, last_block_in_input_buffer);
    end
    rand_msg(10);
    run_message(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit md;
    int len;
    for (int it = 0; it < 14; it++) begin
      md  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       len = md ? 136 * $urandom_range(1, 2) : 168 * $urandom_range(1, 2);
        1:       len = (md ? 136 : 168) - $urandom_range(1, 9);
        default: len = $urandom_range(0, 350);
      endcase
      rand_msg(len);
      run_message(md, $urandom_range(0, 3), 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst                      = 1'b1;
    start                    = 1'b0;
    mode                     = 1'b0;
    in_valid                 = 1'b0;
    in_data                  = '0;
    in_last                  = 1'b0;
    in_bytes                 = 4'd0;
    input_buffer_ready_clr   = 1'b0;
    last_block_in_buffer_clr = 1'b0;
    test_reset();
    test_empty_128();
    test_partial_256();
    test_exact_rate_256();
    test_9f_128();
    test_stall();
    test_reset_mid_fill();
    test_start_with_last();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
